// File: rtl/des_decrypt_core.sv
// des_decrypt_core: iterative DES engine, one Feistel round per clock, 16 rounds
// per 64-bit block. It builds the key schedule on the fly. The decrypt build
// rotates C/D right so that the subkeys come out as K16..K1. The encrypt build
// (DECRYPT=0) rotates left and produces K1..K16.
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready  input handshake; in_data = block, in_key = key (parity ignored)
//   out_valid / out_ready output handshake; out_data = result block
//   busy                 high while a block is in flight or waiting to be taken
//   Bit 63 of every 64-bit port is DES bit 1.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready is high only in IDLE. out_valid is high only in DONE, and
// out_data is held stable there until the transfer. There is no same-cycle
// turnaround: the next block can be accepted one cycle after the output
// transfer at the earliest.
module des_decrypt_core #(
  parameter int DECRYPT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [63:0] in_key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
    12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
    22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10, 23, 19, 12,  4,
    26,  8, 16,  7, 27, 20, 13,  2, 41, 52, 31, 37, 47, 55, 30, 40,
    51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  // Eight S-boxes, 64 entries each, laid out as row*16 + column.
  localparam int S_T [512] = '{
    14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
    0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
    4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
    15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13,
    15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
    3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
    0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
    13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9,
    10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
    13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
    13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
    1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12,
    7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
    13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
    10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
    3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14,
    2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
    14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
    4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
    11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3,
    12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
    10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
    9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
    4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13,
    4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
    13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
    1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
    6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12,
    13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
    1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
    7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
    2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11};

  // Table entries are 1-based DES bit positions counted from the MSB.
  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
    return y;
  endfunction

  function automatic logic [55:0] pc1_perm(input logic [63:0] k);
    logic [55:0] y;
    y = '0;
    for (int i = 0; i < 56; i++) y[55-i] = k[64-PC1_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] cd);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[47-i] = cd[56-PC2_T[i]];
    return y;
  endfunction

  // F-function: E-expansion, key mix, S-boxes, P permutation.
  function automatic logic [31:0] f_func(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s;
    logic [31:0] y;
    logic [5:0]  b;
    e = '0;
    s = '0;
    y = '0;
    for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
    e = e ^ k;
    for (int n = 0; n < 8; n++) begin
      b = e[47-6*n -: 6];
      // Outer bits select the row, inner four bits the column.
      s[31-4*n -: 4] = 4'(S_T[n*64 + 16*int'({b[5], b[0]}) + int'(b[4:1])]);
    end
    for (int i = 0; i < 32; i++) y[31-i] = s[32-P_T[i]];
    return y;
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] x, input logic [1:0] n,
                                        input logic right);
    logic [27:0] y;
    case (n)
      2'd1:    y = right ? {x[0], x[27:1]}   : {x[26:0], x[27]};
      2'd2:    y = right ? {x[1:0], x[27:2]} : {x[25:0], x[27:26]};
      default: y = x;
    endcase
    return y;
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  round_q, round_d;
  logic [31:0] l_q, l_d, r_q, r_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [63:0] out_q, out_d;

  logic [1:0]  shift;
  logic [27:0] c_rot, d_rot;
  logic [31:0] r_new;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)        state_d = RUN;
      RUN:     if (round_q == 4'd15) state_d = DONE;
      DONE:    if (out_ready)       state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  // Round datapath. The decrypt schedule starts from the unrotated PC-1 value,
  // which equals C16/D16, so round 0 uses K16 directly.
  always_comb begin
    shift = 2'd2;
    if (DECRYPT != 0) begin
      case (round_q)
        4'd0:                shift = 2'd0;
        4'd1, 4'd8, 4'd15:   shift = 2'd1;
        default:             shift = 2'd2;
      endcase
    end else begin
      case (round_q)
        4'd0, 4'd1, 4'd8, 4'd15: shift = 2'd1;
        default:                 shift = 2'd2;
      endcase
    end
    c_rot = rot28(c_q, shift, DECRYPT != 0);
    d_rot = rot28(d_q, shift, DECRYPT != 0);
    r_new = l_q ^ f_func(r_q, pc2_perm({c_rot, d_rot}));
  end

  always_comb begin
    l_d     = l_q;
    r_d     = r_q;
    c_d     = c_q;
    d_d     = d_q;
    round_d = round_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          {l_d, r_d} = ip_perm(in_data);
          {c_d, d_d} = pc1_perm(in_key);
          round_d    = 4'd0;
        end
      end
      RUN: begin
        l_d     = r_q;
        r_d     = r_new;
        c_d     = c_rot;
        d_d     = d_rot;
        round_d = round_q + 4'd1;
        // Last round: halves swap before FP, so the preoutput is {R16, L16}.
        if (round_q == 4'd15) out_d = fp_perm({r_new, r_q});
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round_q <= '0;
      l_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      out_q   <= '0;
    end else begin
      round_q <= round_d;
      l_q     <= l_d;
      r_q     <= r_d;
      c_q     <= c_d;
      d_q     <= d_d;
      out_q   <= out_d;
    end
  end

  assign out_data = out_q;

endmodule

// File: tb/tb_des_decrypt_core.sv
// Directed bench for des_decrypt_core. A decrypt instance and an encrypt
// (DECRYPT=0) instance share clock and reset. Expected values come from
// published DES vectors and from a behavioural encrypt model written
// independently here: E is generated arithmetically and FP is taken as the
// inverse of IP.
module tb_des_decrypt_core;

  localparam logic [63:0] K1  = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT1 = 64'h85E813540F0AB405;
  localparam logic [63:0] CT2 = 64'h8CA64DE9C1B123A7;
  localparam logic [63:0] PARITY = 64'h0101010101010101;

  localparam int IP_M [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int P_M [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
  localparam int PC1_M [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_M [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10, 23, 19, 12,  4,
    26,  8, 16,  7, 27, 20, 13,  2, 41, 52, 31, 37, 47, 55, 30, 40,
    51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SBOX_M [512] = '{
    14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
    0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
    4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
    15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13,
    15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
    3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
    0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
    13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9,
    10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
    13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
    13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
    1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12,
    7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
    13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
    10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
    3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14,
    2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
    14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
    4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
    11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3,
    12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
    10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
    9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
    4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13,
    4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
    13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
    1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
    6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12,
    13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
    1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
    7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
    2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_busy;
  logic [63:0] d_in_data, d_in_key, d_out_data;
  logic        e_in_valid, e_in_ready, e_out_valid, e_out_ready, e_busy;
  logic [63:0] e_in_data, e_in_key, e_out_data;

  des_decrypt_core #(.DECRYPT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data), .in_key(d_in_key),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data), .busy(d_busy));

  des_decrypt_core #(.DECRYPT(0)) dut_enc (
    .clk(clk), .rst_n(rst_n),
    .in_valid(e_in_valid), .in_ready(e_in_ready), .in_data(e_in_data), .in_key(e_in_key),
    .out_valid(e_out_valid), .out_ready(e_out_ready), .out_data(e_out_data), .busy(e_busy));

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (encrypt) ----------------
  function automatic logic [63:0] model_enc(input logic [63:0] key, input logic [63:0] pt);
    logic [27:0] c, d;
    logic [55:0] cd;
    logic [47:0] k, e;
    logic [63:0] x, y;
    logic [31:0] l, r, s, f, tmp;
    logic [5:0]  b;
    int          sh, src;
    for (int i = 0; i < 28; i++) begin
      c[27-i] = key[64-PC1_M[i]];
      d[27-i] = key[64-PC1_M[28+i]];
    end
    for (int i = 0; i < 64; i++) x[63-i] = pt[64-IP_M[i]];
    l = x[63:32];
    r = x[31:0];
    for (int rnd = 1; rnd <= 16; rnd++) begin
      sh = (rnd == 1 || rnd == 2 || rnd == 9 || rnd == 16) ? 1 : 2;
      for (int t = 0; t < sh; t++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) k[47-i] = cd[56-PC2_M[i]];
      // E-expansion: group g takes bits 4g..4g+5 (1-based, wrapping mod 32).
      for (int j = 0; j < 48; j++) begin
        src = (4 * (j / 6) + (j % 6) + 31) % 32 + 1;
        e[47-j] = r[32-src];
      end
      e = e ^ k;
      s = '0;
      for (int n = 0; n < 8; n++) begin
        b = e[47-6*n -: 6];
        s[31-4*n -: 4] = 4'(SBOX_M[n*64 + 16*int'({b[5], b[0]}) + int'(b[4:1])]);
      end
      for (int i = 0; i < 32; i++) f[31-i] = s[32-P_M[i]];
      tmp = r;
      r   = l ^ f;
      l   = tmp;
    end
    y = {r, l};
    // FP is the inverse of IP.
    for (int i = 0; i < 64; i++) x[64-IP_M[i]] = y[63-i];
    return x;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_in(input bit enc, input logic v, input logic [63:0] data,
                          input logic [63:0] key);
    if (enc) begin
      e_in_valid = v; e_in_data = data; e_in_key = key;
    end else begin
      d_in_valid = v; d_in_data = data; d_in_key = key;
    end
  endtask

  // Returns #1 after the accepting edge; acc_cyc = edge count at that point.
  task automatic wait_accept(input bit enc, output int acc_cyc);
    bit got;
    got = 1'b0;
    acc_cyc = -1000;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (enc ? (e_in_ready && e_in_valid) : (d_in_ready && d_in_valid)) begin
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        got = 1'b1;
      end
    end
    check1("accept_within_budget", got, 1'b1);
  endtask

  // Returns at the negedge where out_valid is first seen.
  task automatic wait_valid(input bit enc, output int v_cyc, output logic [63:0] data);
    bit got;
    got = 1'b0;
    v_cyc = -1000;
    data = 'x;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (enc ? e_out_valid : d_out_valid) begin
        data  = enc ? e_out_data : d_out_data;
        v_cyc = cyc;
        got   = 1'b1;
      end
    end
    check1("out_valid_within_budget", got, 1'b1);
  endtask

  // One block with out_ready high; lat = edges from accept to output transfer.
  task automatic run_block(input bit enc, input logic [63:0] key, input logic [63:0] data,
                           output logic [63:0] res, output int lat);
    int acc, vc;
    drive_in(enc, 1'b1, data, key);
    wait_accept(enc, acc);
    drive_in(enc, 1'b0, data, key);
    wait_valid(enc, vc, res);
    @(posedge clk);
    #1;
    lat = vc + 1 - acc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [63:0] res, res2, exp;
    logic [63:0] dkeys[100];
    logic [63:0] cts[100];
    logic [63:0] key, pt;
    int lat, acc, prev, vc, pulses;

    rst_n = 1'b0;
    drive_in(1'b0, 1'b0, '0, '0);
    drive_in(1'b1, 1'b0, '0, '0);
    d_out_ready = 1'b1;
    e_out_ready = 1'b1;
    prev = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check1("rst_in_ready", d_in_ready, 1'b1);
    check1("rst_out_valid", d_out_valid, 1'b0);
    check1("rst_busy", d_busy, 1'b0);
    check64("rst_out_data", d_out_data, 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Reference model against published vectors
    check64("model_t1", model_enc(K1, PT1), CT1);
    check64("model_t2", model_enc(64'h0, 64'h0), CT2);

    // T1: standard vector, output transfer 17 edges after accept
    run_block(1'b0, K1, CT1, res, lat);
    check64("t1_data", res, PT1);
    check_int("t1_latency", lat, 17);

    // T2: all-zero key
    run_block(1'b0, 64'h0, CT2, res, lat);
    check64("t2_data", res, 64'h0);

    // T3: encrypt build, then decrypt its result
    run_block(1'b1, K1, PT1, res, lat);
    check64("t3_enc_data", res, CT1);
    check_int("t3_enc_latency", lat, 17);
    run_block(1'b0, K1, res, res2, lat);
    check64("t3_roundtrip", res2, PT1);

    // T4: output backpressure, in_valid pulse while DONE is ignored
    d_out_ready = 1'b0;
    drive_in(1'b0, 1'b1, CT1, K1);
    wait_accept(1'b0, acc);
    drive_in(1'b0, 1'b0, CT1, K1);
    wait_valid(1'b0, vc, res);
    check64("t4_data", res, PT1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (k == 3) drive_in(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, K1);
      else if (k == 4) drive_in(1'b0, 1'b0, 64'h0, K1);
      @(negedge clk);
      check64("t4_hold_data", d_out_data, PT1);
      check1("t4_hold_in_ready", d_in_ready, 1'b0);
      check1("t4_hold_out_valid", d_out_valid, 1'b1);
    end
    @(posedge clk);
    #1 d_out_ready = 1'b1;
    @(posedge clk);
    #1;
    check1("t4_after_out_valid", d_out_valid, 1'b0);
    check1("t4_after_in_ready", d_in_ready, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check1("t4_pulse_ignored_busy", d_busy, 1'b0);

    // T5: reset while round register is 7
    drive_in(1'b0, 1'b1, CT1, K1);
    wait_accept(1'b0, acc);
    drive_in(1'b0, 1'b0, CT1, K1);
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check1("t5_rst_out_valid", d_out_valid, 1'b0);
    check1("t5_rst_in_ready", d_in_ready, 1'b1);
    check1("t5_rst_busy", d_busy, 1'b0);
    check64("t5_rst_out_data", d_out_data, 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check1("t5_rel_in_ready", d_in_ready, 1'b1);
    check1("t5_rel_busy", d_busy, 1'b0);
    pulses = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (d_out_valid) pulses++;
    end
    check_int("t5_no_out_valid", pulses, 0);
    @(posedge clk);
    #1;
    run_block(1'b0, K1, CT1, res, lat);
    check64("t5_next_block", res, PT1);

    // T6: 100 random blocks back to back; odd blocks use flipped parity bits
    for (int i = 0; i < 100; i++) begin
      key = {$urandom(), $urandom()};
      pt  = {$urandom(), $urandom()};
      cts[i]   = model_enc(key, pt);
      dkeys[i] = (i % 2 == 1) ? (key ^ PARITY) : key;
      exp_q.push_back(pt);
    end
    drive_in(1'b0, 1'b1, cts[0], dkeys[0]);
    for (int i = 0; i < 100; i++) begin
      wait_accept(1'b0, acc);
      if (i > 0) check_int($sformatf("t6_spacing_%0d", i), acc - prev, 18);
      prev = acc;
      if (i < 99) drive_in(1'b0, 1'b1, cts[i+1], dkeys[i+1]);
      else        drive_in(1'b0, 1'b0, 64'h0, 64'h0);
      wait_valid(1'b0, vc, res);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'h0;
      check64($sformatf("t6_data_%0d", i), res, exp);
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
